// File: rtl/trig_lut_pipe.sv
// trig_lut_pipe: pipelined sin/cos/tan lookup for integer-degree angles, producing
// IEEE-754 doubles.
//
// Ports
//   clk_i          clock, rising edge
//   reset_ni       asynchronous active-low reset
//   in_valid_i     request present
//   in_ready_o     request can be accepted this cycle (low only while the output stalls)
//   in_mode_i      00 sin, 01 cos, 10 tan, 11 reserved (qNaN + error)
//   in_angle_i     unsigned angle in degrees; >= 360 is an error
//   in_tag_i       opaque tag, returned with the result
//   out_valid_o    result present
//   out_ready_i    consumer accepts the result
//   out_data_o     IEEE-754 double result
//   out_err_o      result is +inf (tan 90/270) or qNaN (bad mode / angle)
//   out_tag_o      tag of the result
//   err_count_o    saturating count of delivered results with out_err_o set
//
// Flow: reduce to quadrant/remainder, form ROM index and sign, read the ROM into a
// registered data stage, finalise into the output register. Every stage holds while
// the output is stalled and everything advances together otherwise.
module trig_lut_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TAG_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [1:0]            in_mode_i,
    input  logic [DATA_WIDTH-1:0] in_angle_i,
    input  logic [TAG_WIDTH-1:0]  in_tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [63:0]           out_data_o,
    output logic                  out_err_o,
    output logic [TAG_WIDTH-1:0]  out_tag_o,
    output logic [15:0]           err_count_o
);

    // pi/180 split into a double and its residual so table entries land within
    // an ulp of the true value instead of inheriting the argument rounding error.
    localparam real DegToRad   = 0.017453292519943295;
    localparam real DegToRadLo = 2.9486522708701687e-19;

    // Magnitudes only (sign bit dropped): S[k] = sin(k deg).
    function automatic logic [62:0] sin_entry(input int k);
        logic [63:0] bits;
        real         x;
        real         dx;
        int          m;
        if (k == 0) begin
            bits = 64'h0;
        end else if (k == 30) begin
            bits = 64'h3FE0000000000000;
        end else if (k == 90) begin
            bits = 64'h3FF0000000000000;
        end else begin
            // Keep the argument at or below 45 deg; sin(k) = cos(90 - k) above that.
            m  = (k > 45) ? 90 - k : k;
            x  = $itor(m) * DegToRad;
            dx = $itor(m) * DegToRadLo;
            if (k > 45) bits = $realtobits($cos(x) - $sin(x) * dx);
            else        bits = $realtobits($sin(x) + $cos(x) * dx);
        end
        return bits[62:0];
    endfunction

    // T[k] = tan(k deg), T[90] = +inf.
    function automatic logic [62:0] tan_entry(input int k);
        logic [63:0] bits;
        real         x;
        real         dx;
        real         t;
        int          m;
        if (k == 0) begin
            bits = 64'h0;
        end else if (k == 45) begin
            bits = 64'h3FF0000000000000;
        end else if (k == 90) begin
            bits = 64'h7FF0000000000000;
        end else begin
            // tan(k) = 1 / tan(90 - k) keeps the argument away from the pole.
            m  = (k > 45) ? 90 - k : k;
            x  = $itor(m) * DegToRad;
            dx = $itor(m) * DegToRadLo;
            t  = $tan(x);
            t  = t + (1.0 + t * t) * dx;
            bits = (k > 45) ? $realtobits(1.0 / t) : $realtobits(t);
        end
        return bits[62:0];
    endfunction

    logic [62:0] sin_rom [91];
    logic [62:0] tan_rom [91];

    for (genvar k = 0; k < 91; k++) begin : g_rom
        assign sin_rom[k] = sin_entry(k);
        assign tan_rom[k] = tan_entry(k);
    end

    // Stage registers.
    logic                 s1_valid_q, s1_valid_d, s1_rerr_q, s1_rerr_d;
    logic [1:0]           s1_mode_q, s1_mode_d, s1_quad_q, s1_quad_d;
    logic [6:0]           s1_rem_q, s1_rem_d;
    logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

    logic                 s2_valid_q, s2_valid_d, s2_tan_q, s2_tan_d, s2_neg_q, s2_neg_d;
    logic                 s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d;
    logic [6:0]           s2_idx_q, s2_idx_d;
    logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;

    logic                 s3_valid_q, s3_valid_d, s3_neg_q, s3_neg_d;
    logic                 s3_nan_q, s3_nan_d, s3_inf_q, s3_inf_d;
    logic [62:0]          s3_mag_q, s3_mag_d;
    logic [TAG_WIDTH-1:0] s3_tag_q, s3_tag_d;

    logic                 out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic [63:0]          out_data_q, out_data_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
    logic [15:0]          err_count_q, err_count_d;

    logic advance;
    logic comp;   // index with 90 - r instead of r
    logic neg;

    assign advance    = !(out_valid_q && !out_ready_i);
    assign in_ready_o = advance;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_rerr_d   = s1_rerr_q;
        s1_mode_d   = s1_mode_q;
        s1_quad_d   = s1_quad_q;
        s1_rem_d    = s1_rem_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_tan_d    = s2_tan_q;
        s2_neg_d    = s2_neg_q;
        s2_nan_d    = s2_nan_q;
        s2_inf_d    = s2_inf_q;
        s2_idx_d    = s2_idx_q;
        s2_tag_d    = s2_tag_q;
        s3_valid_d  = s3_valid_q;
        s3_neg_d    = s3_neg_q;
        s3_nan_d    = s3_nan_q;
        s3_inf_d    = s3_inf_q;
        s3_mag_d    = s3_mag_q;
        s3_tag_d    = s3_tag_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        comp        = 1'b0;
        neg         = 1'b0;

        unique case (s1_mode_q)
            2'd0:    begin comp = s1_quad_q[0];  neg = s1_quad_q[1];                end
            2'd1:    begin comp = ~s1_quad_q[0]; neg = s1_quad_q[0] ^ s1_quad_q[1]; end
            2'd2:    begin comp = s1_quad_q[0];  neg = s1_quad_q[0];                end
            default: begin comp = 1'b0;          neg = 1'b0;                        end
        endcase

        if (advance) begin
            // Reduce.
            s1_valid_d = in_valid_i;
            if (in_valid_i) begin
                s1_mode_d = in_mode_i;
                s1_tag_d  = in_tag_i;
                s1_rerr_d = (in_angle_i >= DATA_WIDTH'(360));
                s1_quad_d = 2'd0;
                s1_rem_d  = 7'd0;
                if (in_angle_i < DATA_WIDTH'(90)) begin
                    s1_rem_d  = 7'(in_angle_i);
                end else if (in_angle_i < DATA_WIDTH'(180)) begin
                    s1_quad_d = 2'd1;
                    s1_rem_d  = 7'(in_angle_i - DATA_WIDTH'(90));
                end else if (in_angle_i < DATA_WIDTH'(270)) begin
                    s1_quad_d = 2'd2;
                    s1_rem_d  = 7'(in_angle_i - DATA_WIDTH'(180));
                end else if (in_angle_i < DATA_WIDTH'(360)) begin
                    s1_quad_d = 2'd3;
                    s1_rem_d  = 7'(in_angle_i - DATA_WIDTH'(270));
                end
            end

            // Index, sign and special flags.
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_tan_d = (s1_mode_q == 2'd2);
                s2_neg_d = neg;
                s2_idx_d = comp ? 7'd90 - s1_rem_q : s1_rem_q;
                s2_nan_d = (s1_mode_q == 2'd3) || s1_rerr_q;
                s2_inf_d = (s1_mode_q == 2'd2) && !s1_rerr_q && s1_quad_q[0] &&
                           (s1_rem_q == 7'd0);
                s2_tag_d = s1_tag_q;
            end

            // ROM read.
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_mag_d = s2_tan_q ? tan_rom[s2_idx_q] : sin_rom[s2_idx_q];
                s3_neg_d = s2_neg_q;
                s3_nan_d = s2_nan_q;
                s3_inf_d = s2_inf_q;
                s3_tag_d = s2_tag_q;
            end

            // Finalise: NaN beats inf, and a zero magnitude never carries a sign.
            out_valid_d = s3_valid_q;
            if (s3_valid_q) begin
                out_tag_d = s3_tag_q;
                out_err_d = s3_nan_q || s3_inf_q;
                if (s3_nan_q)                 out_data_d = 64'h7FF8000000000000;
                else if (s3_inf_q)            out_data_d = 64'h7FF0000000000000;
                else if (s3_mag_q == 63'd0)   out_data_d = 64'h0;
                else                          out_data_d = {s3_neg_q, s3_mag_q};
            end
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (out_valid_q && out_ready_i && out_err_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid_q  <= 1'b0;
            s1_rerr_q   <= 1'b0;
            s1_mode_q   <= 2'd0;
            s1_quad_q   <= 2'd0;
            s1_rem_q    <= 7'd0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_tan_q    <= 1'b0;
            s2_neg_q    <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_idx_q    <= 7'd0;
            s2_tag_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_neg_q    <= 1'b0;
            s3_nan_q    <= 1'b0;
            s3_inf_q    <= 1'b0;
            s3_mag_q    <= 63'd0;
            s3_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= 64'h0;
            out_tag_q   <= '0;
            err_count_q <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_rerr_q   <= s1_rerr_d;
            s1_mode_q   <= s1_mode_d;
            s1_quad_q   <= s1_quad_d;
            s1_rem_q    <= s1_rem_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_tan_q    <= s2_tan_d;
            s2_neg_q    <= s2_neg_d;
            s2_nan_q    <= s2_nan_d;
            s2_inf_q    <= s2_inf_d;
            s2_idx_q    <= s2_idx_d;
            s2_tag_q    <= s2_tag_d;
            s3_valid_q  <= s3_valid_d;
            s3_neg_q    <= s3_neg_d;
            s3_nan_q    <= s3_nan_d;
            s3_inf_q    <= s3_inf_d;
            s3_mag_q    <= s3_mag_d;
            s3_tag_q    <= s3_tag_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_err_o   = out_err_q;
    assign out_tag_o   = out_tag_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_trig_lut_pipe.sv
// Scoreboard bench for trig_lut_pipe: stimulus pushes expected results computed from
// plain trig math; a negedge monitor pops and compares whenever a result is delivered.
module tb_trig_lut_pipe;
    localparam int DW = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_mode = 2'd0;
    logic [DW-1:0] in_angle = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [63:0]   out_data;
    logic          out_err;
    logic [TW-1:0] out_tag;
    logic [15:0]   err_count;

    trig_lut_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_mode_i  (in_mode),
        .in_angle_i (in_angle),
        .in_tag_i   (in_tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_err_o  (out_err),
        .out_tag_o  (out_tag),
        .err_count_o(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [63:0]   bits;
        bit            exact;
        real           val;
        bit            err;
        bit            lat_chk;
        int            acc_cyc;
        int            mode;
        int            angle;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   delivered = 0;
    int   err_model = 0;
    bit   bp_en = 1'b0;
    bit   rdy_val = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready changes 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        out_ready = bp_en ? 1'($urandom % 2) : rdy_val;
    end

    task automatic check(input bit ok, input string name, input logic [63:0] got,
                         input logic [63:0] want);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    function automatic real rabs(input real d);
        return (d < 0.0) ? -d : d;
    endfunction

    function automatic exp_t model(input int mode, input int angle, input logic [TW-1:0] tag);
        exp_t e;
        real  rad;
        real  v;
        real  rv;
        e.tag = tag; e.mode = mode; e.angle = angle;
        e.exact = 1'b1; e.err = 1'b0; e.val = 0.0; e.bits = 64'h0;
        e.lat_chk = 1'b0; e.acc_cyc = 0;
        if (mode == 3 || angle >= 360) begin
            e.bits = 64'h7FF8000000000000;
            e.err  = 1'b1;
        end else if (mode == 2 && (angle == 90 || angle == 270)) begin
            e.bits = 64'h7FF0000000000000;
            e.err  = 1'b1;
        end else if ((mode != 1 && angle % 180 == 0) || (mode == 1 && angle % 180 == 90)) begin
            e.bits = 64'h0;
        end else begin
            rad = $itor(angle) * 3.141592653589793 / 180.0;
            v = (mode == 0) ? $sin(rad) : (mode == 1) ? $cos(rad) : $tan(rad);
            // Values that are really +-0.5 or +-1 must come out exact.
            rv = $itor($rtoi(v * 2.0 + ((v >= 0.0) ? 0.5 : -0.5))) / 2.0;
            if (rv != 0.0 && rabs(rv - v) < 1e-12) begin
                e.bits = $realtobits(rv);
            end else begin
                e.exact = 1'b0;
                e.val   = v;
            end
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int mode, input int angle, input logic [TW-1:0] tag,
                         input bit lat);
        exp_t e;
        bit   acc;
        int   acc_c;
        int   n;
        acc = 1'b0; acc_c = 0; n = 0;
        in_valid = 1'b1;
        in_mode  = 2'(mode);
        in_angle = DW'(angle);
        in_tag   = tag;
        while (!acc) begin
            @(negedge clk);
            acc   = in_ready;
            acc_c = cyc;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                check(1'b0, "accept_timeout", 64'(n), 64'd200);
                break;
            end
        end
        if (acc) begin
            e = model(mode, angle, tag);
            e.lat_chk = lat;
            e.acc_cyc = acc_c;
            sb.push_back(e);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor.
    logic [63:0]   p_data;
    logic          p_err;
    logic [TW-1:0] p_tag;
    bit            p_stall = 1'b0;
    exp_t          me;
    real           got_r;
    bit            ok_r;

    always @(negedge clk) begin
        if (!reset_n) begin
            p_stall = 1'b0;
        end else begin
            check(in_ready == !(out_valid && !out_ready), "in_ready", 64'(in_ready),
                  64'(!(out_valid && !out_ready)));
            if (p_stall) begin
                check(out_valid && out_data == p_data && out_err == p_err && out_tag == p_tag,
                      "stall_hold", out_data, p_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check(1'b0, "unexpected_output", out_data, 64'h0);
                end else begin
                    me = sb.pop_front();
                    delivered++;
                    if (me.err) err_model++;
                    check(out_tag == me.tag, $sformatf("tag m%0d a%0d", me.mode, me.angle),
                          64'(out_tag), 64'(me.tag));
                    check(out_err == me.err, $sformatf("err m%0d a%0d", me.mode, me.angle),
                          64'(out_err), 64'(me.err));
                    if (me.exact) begin
                        check(out_data == me.bits,
                              $sformatf("data m%0d a%0d", me.mode, me.angle), out_data,
                              me.bits);
                    end else begin
                        got_r = $bitstoreal(out_data);
                        ok_r  = (out_data[63] == (me.val < 0.0)) &&
                                (rabs(got_r - me.val) <= 1e-12 * rabs(me.val));
                        check(ok_r, $sformatf("approx m%0d a%0d", me.mode, me.angle),
                              out_data, $realtobits(me.val));
                    end
                    if (me.lat_chk) begin
                        check(cyc == me.acc_cyc + 4,
                              $sformatf("latency m%0d a%0d", me.mode, me.angle),
                              64'(cyc - me.acc_cyc - 1), 64'd3);
                    end
                end
            end
            p_stall = out_valid && !out_ready;
            p_data  = out_data;
            p_err   = out_err;
            p_tag   = out_tag;
        end
    end

    initial begin
        int d0;
        int md;
        int an;
        int n;

        #2 reset_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
        check(out_data == 64'h0, "rst_out_data", out_data, 64'h0);
        check(out_err == 1'b0, "rst_out_err", 64'(out_err), 64'd0);
        check(out_tag == '0, "rst_out_tag", 64'(out_tag), 64'd0);
        check(err_count == 16'd0, "rst_err_count", 64'(err_count), 64'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);

        // Sin sweep, back-to-back, fixed latency.
        d0 = delivered;
        for (int a = 0; a < 360; a++) issue(0, a, TW'(a), 1'b1);
        wait_drain();
        check(delivered - d0 == 360, "sweep_count", 64'(delivered - d0), 64'd360);

        // Mode coverage plus random error-free cos/tan/sin.
        issue(1, 60, 4'h1, 1'b1);
        issue(1, 180, 4'h2, 1'b1);
        issue(1, 90, 4'h3, 1'b1);
        issue(2, 45, 4'h4, 1'b1);
        issue(2, 135, 4'h5, 1'b1);
        issue(2, 180, 4'h6, 1'b1);
        for (int i = 0; i < 40; i++) begin
            md = int'($urandom % 3);
            an = int'($urandom % 360);
            if (md == 2 && an % 180 == 90) an = an + 1;
            issue(md, an, TW'($urandom), 1'b1);
        end
        wait_drain();

        // Specials.
        issue(2, 90, 4'h7, 1'b1);
        issue(2, 270, 4'h8, 1'b1);
        issue(0, 360, 4'h9, 1'b1);
        issue(3, 45, 4'hA, 1'b1);
        wait_drain();
        check(err_count == 16'd4, "err_count_specials", 64'(err_count), 64'd4);

        // Backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(int'($urandom % 4), int'($urandom % 400), TW'($urandom), 1'b0);
        end
        wait_drain();
        bp_en = 1'b0;
        rdy_val = 1'b1;
        @(posedge clk);
        #1;
        check(err_count == 16'(err_model), "err_count_bp", 64'(err_count), 64'(err_model));

        // Reset with three transactions in flight and the output stalled.
        rdy_val = 1'b0;
        issue(2, 10, 4'h1, 1'b0);
        issue(0, 20, 4'h2, 1'b0);
        issue(1, 30, 4'h3, 1'b0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(out_valid == 1'b1, "fill_before_reset", 64'(out_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check(out_valid == 1'b0, "reset_drops_valid", 64'(out_valid), 64'd0);
        check(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        check(err_count == 16'd0, "reset_err_count", 64'(err_count), 64'd0);
        sb.delete();
        err_model = 0;
        rdy_val = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check(out_valid == 1'b0, "no_stale_after_reset", 64'(out_valid), 64'd0);
        issue(2, 0, 4'hC, 1'b1);
        wait_drain();

        // Saturation.
        for (int i = 0; i < 65540; i++) issue(3, int'($urandom % 360), TW'(i), 1'b0);
        wait_drain();
        check(err_model >= 65540, "sat_model_count", 64'(err_model), 64'd65540);
        check(err_count == 16'hFFFF, "err_count_saturated", 64'(err_count), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
